// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - BIP FETCH/EXEC/HALT sequencer, PC, IR and instruction decode (optional BIP_CYCLE_COUNT_EN counters)
module bip_control_unit #(
    parameter int NB_DATA            = 16,
    parameter int NB_OPCODE          = 5,
    parameter int NB_OPERAND         = 11,
    parameter int N_INSMEM_ADDR      = 2048,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int LOG2_N_DATA_ADDR   = 10,
    parameter int NB_SEL_A           = 2
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic [NB_DATA-1:0]            i_instruction,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_insmem_addr,
    output logic [NB_OPERAND-1:0]         o_operand,
    output logic [LOG2_N_DATA_ADDR-1:0]   o_data_addr,
    output logic [NB_SEL_A-1:0]           o_sel_a,
    output logic                          o_sel_b,
    output logic                          o_op_code,
    output logic                          o_wr_acc,
    output logic                          o_wr_ram,
    output logic                          o_rd_ram,
`ifdef BIP_CYCLE_COUNT_EN
    output logic [31:0]                   o_cycle_count,
    output logic [LOG2_N_INSMEM_ADDR:0]   o_instr_count,
`endif
    output logic                          o_halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
    localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
    localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
    localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
    localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
    localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
    localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
    localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

    state_t                          r_state;
    logic [LOG2_N_INSMEM_ADDR-1:0]   r_pc;
    logic [NB_DATA-1:0]              r_ir;

    logic [NB_OPCODE-1:0]            w_opcode;
    logic                            w_exec;
    logic [NB_SEL_A-1:0]             w_sel_a;
    logic                            w_sel_b;
    logic                            w_op_code;
    logic                            w_wr_acc;
    logic                            w_wr_ram;
    logic                            w_rd_ram;

    assign w_opcode = r_ir[NB_DATA-1 -: NB_OPCODE];
    // Strobes only fire on a valid EXEC cycle; the datapath samples on its closing edge.
    assign w_exec   = (r_state == EXEC) && i_valid;

    // Sequencer: fetch latches IR, exec advances PC or parks in HALT; i_valid low freezes everything.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else if (i_valid) begin
            case (r_state)
                FETCH: begin
                    r_ir    <= i_instruction;
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (w_opcode == OP_HLT) begin
                        r_state <= HALT;
                    end else begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= HALT;
            endcase
        end
    end

    // Decode IR into selectors and raw strobes; selectors may settle before EXEC.
    always_comb begin
        w_sel_a   = 2'b00;
        w_sel_b   = 1'b0;
        w_op_code = 1'b0;
        w_wr_acc  = 1'b0;
        w_wr_ram  = 1'b0;
        w_rd_ram  = 1'b0;
        case (w_opcode)
            OP_STO:  w_wr_ram = 1'b1;
            OP_LD:   begin w_rd_ram = 1'b1; w_wr_acc = 1'b1; end
            OP_LDI:  begin w_sel_a = 2'b01; w_wr_acc = 1'b1; end
            OP_ADD:  begin w_rd_ram = 1'b1; w_sel_a = 2'b10; w_op_code = 1'b1; w_wr_acc = 1'b1; end
            OP_ADDI: begin w_sel_a = 2'b10; w_sel_b = 1'b1; w_op_code = 1'b1; w_wr_acc = 1'b1; end
            OP_SUB:  begin w_rd_ram = 1'b1; w_sel_a = 2'b10; w_wr_acc = 1'b1; end
            OP_SUBI: begin w_sel_a = 2'b10; w_sel_b = 1'b1; w_wr_acc = 1'b1; end
            default: ;
        endcase
    end

    assign o_insmem_addr = r_pc;
    assign o_operand     = r_ir[NB_OPERAND-1:0];
    assign o_data_addr   = r_ir[LOG2_N_DATA_ADDR-1:0];
    assign o_sel_a       = w_sel_a;
    assign o_sel_b       = w_sel_b;
    assign o_op_code     = w_op_code;
    assign o_wr_acc      = w_wr_acc && w_exec;
    assign o_wr_ram      = w_wr_ram && w_exec;
    assign o_rd_ram      = w_rd_ram && w_exec;
    assign o_halted      = (r_state == HALT);

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0]                 r_cycle_count;
    logic [LOG2_N_INSMEM_ADDR:0] r_instr_count;

    // Activity counters: valid non-halted cycles, and completed EXEC phases (HLT included).
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (i_valid && (r_state != HALT)) r_cycle_count <= r_cycle_count + 1'b1;
            if (w_exec)                       r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign o_cycle_count = r_cycle_count;
    assign o_instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - directed self-checking bench for bip_control_unit
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] instr;
    logic [10:0] pc;
    logic [10:0] operand;
    logic [9:0]  data_addr;
    logic [1:0]  sel_a;
    logic        sel_b, op_code, wr_acc, wr_ram, rd_ram, halted;
`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
    logic [11:0] instr_count;
`endif

    logic [15:0] mem [0:2047];
    int n_checks = 0;
    int n_fail   = 0;
    logic seen_strobe;

    always #5 clk = ~clk;
    assign instr = mem[pc];

    bip_control_unit dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_valid       (valid),
        .i_instruction (instr),
        .o_insmem_addr (pc),
        .o_operand     (operand),
        .o_data_addr   (data_addr),
        .o_sel_a       (sel_a),
        .o_sel_b       (sel_b),
        .o_op_code     (op_code),
        .o_wr_acc      (wr_acc),
        .o_wr_ram      (wr_ram),
        .o_rd_ram      (rd_ram),
`ifdef BIP_CYCLE_COUNT_EN
        .o_cycle_count (cycle_count),
        .o_instr_count (instr_count),
`endif
        .o_halted      (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) mem[i] = w;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        fill(16'h0000);
        mem[0] = 16'h1805;
        mem[1] = 16'h2803;
        mem[2] = 16'h0807;
        mem[3] = 16'h0000;

        // Reset state
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_strobes", {wr_acc, wr_ram, rd_ram}, 0);
        chk("rst_sel", {sel_a, sel_b, op_code}, 0);
        chk("rst_halted", halted, 0);
        chk("rst_operand", operand, 0);

        // Program: LDI 5, ADDI 3, STO 7, HLT
        tick();
        chk("ldi_sel_a", sel_a, 2'b01);
        chk("ldi_wr_acc", wr_acc, 1);
        chk("ldi_operand", operand, 5);
        chk("ldi_other", {wr_ram, rd_ram}, 0);
        tick();
        chk("fetch2_pc", pc, 1);
        chk("fetch2_strobes", {wr_acc, wr_ram, rd_ram}, 0);
        tick();
        chk("addi_sel", {sel_a, sel_b, op_code}, 4'b1011);
        chk("addi_wr_acc", wr_acc, 1);
        tick();
        tick();
        chk("sto_wr_ram", wr_ram, 1);
        chk("sto_data_addr", data_addr, 7);
        chk("sto_wr_acc", wr_acc, 0);
        tick();
        tick();
        chk("hlt_exec_strobes", {wr_acc, wr_ram, rd_ram}, 0);
        chk("hlt_exec_halted", halted, 0);
        tick();
        chk("halted", halted, 1);
        chk("halt_pc", pc, 3);
`ifdef BIP_CYCLE_COUNT_EN
        chk("cycle_count", cycle_count, 8);
        chk("instr_count", instr_count, 4);
`endif
        tick();
        tick();
        tick();
        chk("halt_hold", halted, 1);
        chk("halt_pc_hold", pc, 3);
        chk("halt_strobes", {wr_acc, wr_ram, rd_ram}, 0);
`ifdef BIP_CYCLE_COUNT_EN
        chk("cycle_count_frozen", cycle_count, 8);
        chk("instr_count_frozen", instr_count, 4);
`endif

        // SUB 0x004
        mem[0] = 16'h3004;
        do_reset();
        chk("sub_reset_halted", halted, 0);
        tick();
        chk("sub_sel", {sel_a, sel_b, op_code}, 4'b1000);
        chk("sub_strobes", {wr_acc, wr_ram, rd_ram}, 3'b101);
        chk("sub_data_addr", data_addr, 4);

        // LD 4 with i_valid low during EXEC
        mem[0] = 16'h1004;
        do_reset();
        tick();
        valid = 1'b0;
        #1;
        chk("stall_strobes0", {wr_acc, wr_ram, rd_ram}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_strobes", {wr_acc, wr_ram, rd_ram}, 0);
            chk("stall_pc", pc, 0);
        end
        valid = 1'b1;
        #1;
        chk("ld_rd_ram", rd_ram, 1);
        chk("ld_wr_acc_sel", {wr_acc, sel_a}, 3'b100);
        tick();
        chk("ld_pc_adv", pc, 1);

        // Reset during EXEC of STO
        mem[0] = 16'h0807;
        do_reset();
        tick();
        chk("sto2_wr_ram", wr_ram, 1);
        rst = 1'b1;
        tick();
        chk("rst_exec_wr_ram", wr_ram, 0);
        chk("rst_exec_pc", pc, 0);
        rst = 1'b0;
        tick();
        chk("rst_exec_refetch", wr_ram, 1);

        // PC wrap across 2047 NOPs
        fill(16'hF800);
        do_reset();
        seen_strobe = 1'b0;
        for (int i = 0; i < 2047; i++) begin
            tick();
            seen_strobe |= (wr_acc | wr_ram | rd_ram);
            tick();
        end
        chk("nop_pc_2047", pc, 2047);
        tick();
        seen_strobe |= (wr_acc | wr_ram | rd_ram);
        tick();
        chk("nop_pc_wrap", pc, 0);
        chk("nop_no_strobes", seen_strobe, 0);
        chk("nop_not_halted", halted, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
